// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, ALU ops,
// opcodes and datapath mux selects.
package riscv_pkg;

   localparam int unsigned STATE_W = 4;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECR    = 4'd6;
   localparam state_t S_EXECI    = 4'd7;
   localparam state_t S_ALUWB    = 4'd8;
   localparam state_t S_BRANCH   = 4'd9;
   localparam state_t S_JAL      = 4'd10;
   localparam state_t S_JALR     = 4'd11;
   localparam state_t S_JALRLINK = 4'd12;
   localparam state_t S_LUI      = 4'd13;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_ctrl_t;

   // Operation class handed from the FSM to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'd0,
      ALUOP_BRANCH = 2'd1,
      ALUOP_FUNCT  = 2'd2
   } alu_op_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_OLDPC = 2'd1;
   localparam logic [1:0] SRC_A_RS1   = 2'd2;
   localparam logic [1:0] SRC_A_ZERO  = 2'd3;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's operation class plus funct fields to a concrete ALU operation.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  alu_op_t    alu_op,
   output alu_ctrl_t  alu_ctrl
);

   logic is_rtype;
   assign is_rtype = (opcode == OP_OP);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_BRANCH: begin
            case (funct3[2:1])
               2'b10:   alu_ctrl = ALU_SLT;
               2'b11:   alu_ctrl = ALU_SLTU;
               default: alu_ctrl = ALU_SUB;
            endcase
         end
         // funct7_5 means SUB only for R-type; for shifts it selects SRA in both forms
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core; outputs are combinational from
// state plus the memory handshake, branch flag and funct3.
module multicycle_control
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_ctrl,
   output logic [2:0] imm_src,
   output logic [1:0] result_sel,
   output logic       illegal_instr
);

   state_t    state, state_next;
   alu_op_t   alu_op;
   alu_ctrl_t dec_ctrl;
   logic      taken;

   alu_decoder u_alu_decoder (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_op   (alu_op),
      .alu_ctrl (dec_ctrl)
   );

   assign taken    = alu_zero ^ (funct3[2] ^ funct3[0]);
   assign alu_ctrl = rst ? 4'd0 : 4'(dec_ctrl);

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALUOP_ADD;
      result_sel    = RES_ALUOUT;
      illegal_instr = 1'b0;

      case (opcode)
         OP_STORE:         imm_src = IMM_S;
         OP_BRANCH:        imm_src = IMM_B;
         OP_LUI, OP_AUIPC: imm_src = IMM_U;
         OP_JAL:           imm_src = IMM_J;
         default:          imm_src = IMM_I;
      endcase

      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRC_B_FOUR;
            result_sel = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_next = S_DECODE;
         end
         // ALU_out <- oldPC + imm is precomputed here for branches, JAL and AUIPC
         S_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_OP:             state_next = S_EXECR;
               OP_OPIMM:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = S_LUI;
               OP_AUIPC:          state_next = S_ALUWB;
               default: begin
                  state_next    = S_FETCH;
                  illegal_instr = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_sel = RES_MEM;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            result_sel = RES_ALUOUT;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         // funct3 01x has no branch encoding: never taken, flagged illegal
         S_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALUOP_BRANCH;
            result_sel = RES_ALUOUT;
            if (funct3[2:1] == 2'b01) illegal_instr = 1'b1;
            else                      pc_write      = taken;
            state_next = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRC_A_OLDPC;
            alu_src_b  = SRC_B_FOUR;
            result_sel = RES_ALUOUT;
            pc_write   = 1'b1;
            state_next = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            result_sel = RES_ALU;
            pc_write   = 1'b1;
            state_next = S_JALRLINK;
         end
         S_JALRLINK: begin
            alu_src_a  = SRC_A_OLDPC;
            alu_src_b  = SRC_B_FOUR;
            state_next = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a  = SRC_A_ZERO;
            alu_src_b  = SRC_B_IMM;
            state_next = S_ALUWB;
         end
         default: state_next = S_FETCH;
      endcase

      // Reset abandons any access in flight: nothing may request or write
      if (rst) begin
         mem_req       = 1'b0;
         mem_write     = 1'b0;
         adr_src       = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 2'd0;
         alu_src_b     = 2'd0;
         imm_src       = 3'd0;
         result_sel    = 2'd0;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, IR, register file, ALU, registered ALU output and the result mux) one instruction at a time. It drives every mux select and write enable, including `result_sel`, which feeds the result mux. It waits on a single-port instruction/data memory through a request/ready handshake.

## Interface
Parameters:
- none. Encodings live in the shared package.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `opcode`  in  7  `IR[6:0]`.
- `funct3`  in  3  `IR[14:12]`.
- `funct7_5`  in  1  `IR[30]`.
- `alu_zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  the access is a store.
- `adr_src`  out  1  address source: 0 = PC, 1 = `ALU_out`.
- `ir_write`  out  1  latch IR and old PC.
- `pc_write`  out  1  load PC from the result bus.
- `reg_write`  out  1  write the result bus to `rd`.
- `alu_src_a`  out  2  0 = PC, 1 = old PC, 2 = rs1, 3 = zero.
- `alu_src_b`  out  2  0 = rs2, 1 = imm, 2 = const 4.
- `alu_ctrl`  out  4  ALU operation (package enum).
- `imm_src`  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `result_sel`  out  2  0 = `ALU_out` (registered), 1 = memory data, 2 = ALU result (direct).
- `illegal_instr`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRLINK, LUI.
- Defaults:
  - all enables 0, `mem_req` 0.
  - selects 0, `alu_ctrl` = ADD.
  - `imm_src` is always decoded combinationally from `opcode`.
- Per-state outputs and transitions:
  - **FETCH**: `mem_req`, a=0, b=2, ADD, result_sel=2. `ir_write` and `pc_write` equal `mem_ready`. Hold until `mem_ready`, then go to DECODE.
  - **DECODE**: a=1, b=1, ADD (`ALU_out` ← oldPC+imm). Next state by opcode:
    - load/store → MEMADR
    - OP → EXECR
    - OP-IMM → EXECI
    - BRANCH → BRANCH
    - JAL → JAL
    - JALR → JALR
    - LUI → LUI
    - AUIPC → ALUWB
    - anything else → FETCH with `illegal_instr`=1.
  - **MEMADR**: a=2, b=1, ADD. Load → MEMREAD; store → MEMWRITE.
  - **MEMREAD**: `mem_req`, adr_src=1. Hold until `mem_ready`, then MEMWB.
  - **MEMWB**: result_sel=1, `reg_write`. Then FETCH.
  - **MEMWRITE**: `mem_req`, `mem_write`, adr_src=1. Hold until `mem_ready`, then FETCH.
  - **EXECR**: a=2, b=0, alu_ctrl from the decoder (funct7_5 selects SUB/SRA). Then ALUWB.
  - **EXECI**: a=2, b=1, decoder ctrl; funct7_5 is honoured only for shifts (SRAI). Then ALUWB.
  - **ALUWB**: result_sel=0, `reg_write`. Then FETCH.
  - **BRANCH**: a=2, b=0, result_sel=0. alu_ctrl: SUB for funct3 00x, SLT for 10x, SLTU for 11x.
    - taken = `alu_zero` ^ (funct3[2] ^ funct3[0]).
    - `pc_write` = taken. Then FETCH.
    - funct3 01x: not taken, `illegal_instr` pulse.
  - **JAL**: a=1, b=2, ADD, result_sel=0, `pc_write`. Then ALUWB (rd ← oldPC+4).
  - **JALR**: a=2, b=1, ADD, result_sel=2, `pc_write`. Then JALRLINK.
  - **JALRLINK**: a=1, b=2, ADD. Then ALUWB.
  - **LUI**: a=3, b=1, ADD. Then ALUWB.
- The FSM never checks `rd`=x0; the register file ignores writes to x0.

## Timing
- `rst` high at an edge → state = FETCH next cycle. While `rst` is high, every output is forced to 0, including `mem_req`.
- Reset mid-access abandons the access; no write enable may assert in that cycle.
- Outputs are combinational from state plus (`mem_ready`, `alu_zero`, funct3). No output is registered.
- Cycles per instruction with `mem_ready` tied high:
  - 3: branch, AUIPC
  - 4: R, I, LUI, JAL, store
  - 5: load, JALR
- Each memory wait cycle adds 1 cycle.
- `mem_req` and `mem_write` are stable from request until the `mem_ready` cycle inclusive. The access completes in the cycle `mem_ready`=1, and the FSM leaves the state at that edge.
- `mem_ready` outside FETCH/MEMREAD/MEMWRITE is ignored.
- `illegal_instr` is asserted only in DECODE (or BRANCH), for exactly one cycle.

## Structure
- Package `riscv_pkg`:
  - `state_t` enum
  - `alu_ctrl_t` (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU)
  - opcode constants
  - `imm_src` and `result_sel` localparams.
- Sub-module `alu_decoder` (opcode, funct3, funct7_5, alu_op class → alu_ctrl).
- The FSM instantiates `alu_decoder`; the immediate decode stays inline.

## Test plan
- **ADD** (0x00B50533) with `mem_ready`=1 → FETCH→DECODE→EXECR→ALUWB. `reg_write`=1 with result_sel=0 in cycle 4 only.
- **LW**, `mem_ready` low 2 cycles in MEMREAD → `mem_req`/adr_src=1 held 3 cycles. MEMWB follows with result_sel=1, `reg_write`; total 7 cycles.
- **Branch cases** (`alu_zero` forced per case) → `pc_write` only when taken:
  - BEQ, `alu_zero`=1 → `pc_write`=1.
  - BNE, `alu_zero`=1 → `pc_write`=0.
  - BLTU, `alu_zero`=0 → alu_ctrl=SLTU, `pc_write`=1.
- **JALR** → PC write in JALR (result_sel=2), ALU a=1/b=2 in JALRLINK, `reg_write` in ALUWB; 5 cycles.
- **Opcode 0x7F** → `illegal_instr` pulses in DECODE, next state FETCH, no `reg_write`/`mem_write`.
- **`rst` asserted in MEMWRITE** with `mem_ready`=0 → `mem_req`/`mem_write` are 0 that cycle, FETCH next cycle, no store issued.
